// File: rtl/spm_lsu_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spm_lsu_bridge_pkg
// Description : Shared encodings for the scratchpad load/store bridge:
//               access-size codes, FSM state type, read latency and the
//               alignment rule.
// Revision    : 1.0 - initial release
// ============================================================================
package spm_lsu_bridge_pkg;

  // CPU access-size encodings
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Cycles from spmCs to valid dataFromSpm; the two RD_WAIT states cover it
  localparam int unsigned SPM_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT1 = 2'd1,
    ST_RD_WAIT2 = 2'd2,
    ST_RD_DONE  = 2'd3
  } lsu_state_e;

  // Illegal size, odd halfword, or word not on a 4-byte boundary
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE:    bad = 1'b0;
      SIZE_HALF:    bad = offset[0];
      SIZE_WORD:    bad = (offset != 2'b00);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spm_lsu_bridge_load_align.sv
`default_nettype none
// ============================================================================
// Module      : spm_load_align
// Description : Moves the addressed byte/half of a raw scratchpad word down to
//               bit 0 and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_load_align
  import spm_lsu_bridge_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] aligned
);

  logic [31:0] shifted;

  // Shift the selected lane down, then extend according to size and sign
  always_comb begin
    shifted = raw_word >> {offset, 3'b000};
    aligned = shifted;
    case (size)
      SIZE_BYTE: aligned = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: aligned = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default:   aligned = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/spm_lsu_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spm_lsu_bridge
// Description : Decodes CPU data accesses in the scratchpad window, drives the
//               word-addressed scratchpad port, waits out the registered read
//               latency and returns aligned, extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_lsu_bridge
  import spm_lsu_bridge_pkg::*;
#(
  parameter logic [31:0] spmBaseAddress = 32'hC000_0000,
  parameter int unsigned spmSizeInBytes = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuRequest,
  input  logic [31:0] cpuAddress,
  input  logic        cpuWe,
  input  logic [1:0]  cpuSize,
  input  logic        cpuSigned,
  input  logic [31:0] cpuStoreData,
  output logic        cpuHit,
  output logic        cpuBusy,
  output logic        cpuDone,
  output logic        cpuError,
  output logic [31:0] cpuLoadData,
  output logic        spmCs,
  output logic        spmWe,
  output logic [17:0] spmAddress,
  output logic [3:0]  spmByteEnables,
  output logic [31:0] dataToSpm,
  input  logic [31:0] dataFromSpm
);

  // 33-bit window bounds so base + size cannot wrap past 2^32
  localparam logic [32:0] WIN_LO = {1'b0, spmBaseAddress};
  localparam logic [32:0] WIN_HI = {1'b0, spmBaseAddress} + 33'(spmSizeInBytes);

  lsu_state_e  state_q, state_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [31:0] load_data_q, load_data_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;

  logic        in_window;
  logic        can_accept;
  logic        accept;
  logic        misaligned;
  logic        spm_go;
  logic        load_go;
  logic [3:0]  lanes;
  logic [31:0] store_word;
  logic [31:0] aligned_word;

  // Address decode, accept qualification and store lane generation
  always_comb begin
    in_window  = ({1'b0, cpuAddress} >= WIN_LO) && ({1'b0, cpuAddress} < WIN_HI);
    can_accept = (state_q == ST_IDLE) || (state_q == ST_RD_DONE);
    accept     = cpuRequest & in_window & can_accept;
    misaligned = is_misaligned(cpuSize, cpuAddress[1:0]);
    spm_go     = accept & ~misaligned;
    load_go    = spm_go & ~cpuWe;

    lanes      = 4'b1111;
    store_word = cpuStoreData;
    case (cpuSize)
      SIZE_BYTE: begin
        lanes      = 4'b0001 << cpuAddress[1:0];
        store_word = {4{cpuStoreData[7:0]}};
      end
      SIZE_HALF: begin
        lanes      = cpuAddress[1] ? 4'b1100 : 4'b0011;
        store_word = {2{cpuStoreData[15:0]}};
      end
      default: begin
        lanes      = 4'b1111;
        store_word = cpuStoreData;
      end
    endcase
  end

  spm_load_align u_align (
    .raw_word  (dataFromSpm),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .aligned   (aligned_word)
  );

  // Next-state, completion pulses and load-result capture
  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    off_d       = off_q;
    size_d      = size_q;
    signed_d    = signed_q;
    done_d      = accept & (cpuWe | misaligned);
    error_d     = accept & misaligned;

    case (state_q)
      ST_IDLE:     state_d = load_go ? ST_RD_WAIT1 : ST_IDLE;
      ST_RD_WAIT1: state_d = ST_RD_WAIT2;
      ST_RD_WAIT2: begin
        state_d     = ST_RD_DONE;
        load_data_d = aligned_word;
        done_d      = 1'b1;
      end
      ST_RD_DONE:  state_d = load_go ? ST_RD_WAIT1 : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (load_go) begin
      off_d    = cpuAddress[1:0];
      size_d   = cpuSize;
      signed_d = cpuSigned;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      load_data_q <= 32'd0;
      off_q       <= 2'd0;
      size_q      <= SIZE_BYTE;
      signed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      error_q     <= error_d;
      load_data_q <= load_data_d;
      off_q       <= off_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
    end
  end

  assign cpuHit         = cpuRequest & in_window;
  assign cpuBusy        = (state_q == ST_RD_WAIT1) || (state_q == ST_RD_WAIT2);
  assign cpuDone        = done_q;
  assign cpuError       = error_q;
  assign cpuLoadData    = load_data_q;
  assign spmCs          = spm_go;
  assign spmWe          = spm_go & cpuWe;
  assign spmAddress     = spm_go ? 18'((cpuAddress - spmBaseAddress) >> 2) : 18'd0;
  assign spmByteEnables = spm_go ? lanes : 4'd0;
  assign dataToSpm      = spm_go ? store_word : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_spm_lsu_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_lsu_bridge
// Description : Self-checking bench for spm_lsu_bridge with a scratchpad
//               model behind it and a byte-array reference of CPU memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_lsu_bridge;

  localparam logic [31:0] BASE = 32'hC000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpuRequest;
  logic [31:0] cpuAddress;
  logic        cpuWe;
  logic [1:0]  cpuSize;
  logic        cpuSigned;
  logic [31:0] cpuStoreData;
  logic        cpuHit, cpuBusy, cpuDone, cpuError;
  logic [31:0] cpuLoadData;
  logic        spmCs, spmWe;
  logic [17:0] spmAddress;
  logic [3:0]  spmByteEnables;
  logic [31:0] dataToSpm;
  logic [31:0] dataFromSpm;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference memory: CPU-visible bytes of the first 64 bytes of the window
  logic [7:0] ref_mem [64];

  spm_lsu_bridge #(.spmBaseAddress(BASE), .spmSizeInBytes(2048)) dut (
    .clock(clock), .reset(reset), .cpuRequest(cpuRequest), .cpuAddress(cpuAddress),
    .cpuWe(cpuWe), .cpuSize(cpuSize), .cpuSigned(cpuSigned), .cpuStoreData(cpuStoreData),
    .cpuHit(cpuHit), .cpuBusy(cpuBusy), .cpuDone(cpuDone), .cpuError(cpuError),
    .cpuLoadData(cpuLoadData), .spmCs(spmCs), .spmWe(spmWe), .spmAddress(spmAddress),
    .spmByteEnables(spmByteEnables), .dataToSpm(dataToSpm), .dataFromSpm(dataFromSpm)
  );

  always #5 clock = ~clock;

  // Scratchpad model: byte-lane writes, read data valid two cycles after spmCs
  logic [31:0] spm_mem [512];
  logic [31:0] rd_pipe;
  always @(posedge clock) begin
    if (spmCs && spmWe)
      for (int b = 0; b < 4; b++)
        if (spmByteEnables[b]) spm_mem[spmAddress[8:0]][8*b +: 8] <= dataToSpm[8*b +: 8];
    rd_pipe     <= (spmCs && !spmWe) ? spm_mem[spmAddress[8:0]] : 32'hDEAD_BEEF;
    dataFromSpm <= rd_pipe;
  end

  task automatic drive(input logic req, input logic [31:0] a, input logic we,
                       input logic [1:0] sz, input logic sg, input logic [31:0] d);
    cpuRequest = req; cpuAddress = a; cpuWe = we; cpuSize = sz; cpuSigned = sg; cpuStoreData = d;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int off;
    off = int'(a - BASE);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[off + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    int off, n;
    off = int'(a - BASE);
    n   = nbytes(sz);
    v   = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic test_reset();
    drive(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if ({cpuDone, cpuError, cpuBusy} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {cpuDone, cpuError, cpuBusy}); else n_pass++;
    n_checks++; if (cpuLoadData !== 32'd0) $display("FAIL reset_loaddata: got %h expected 0", cpuLoadData); else n_pass++;
    n_checks++; if ({cpuHit, spmCs, spmWe} !== 3'b000) $display("FAIL reset_comb: got %b expected 000", {cpuHit, spmCs, spmWe}); else n_pass++;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_store_byte();
    @(negedge clock);
    drive(1'b1, 32'hC000_0003, 1'b1, 2'd0, 1'b0, 32'h1234_56A5);
    #1;
    n_checks++; if ({spmCs, spmWe} !== 2'b11) $display("FAIL st_cs_we: got %b expected 11", {spmCs, spmWe}); else n_pass++;
    n_checks++; if (spmAddress !== 18'd0) $display("FAIL st_addr: got %h expected 0", spmAddress); else n_pass++;
    n_checks++; if (spmByteEnables !== 4'b1000) $display("FAIL st_be: got %b expected 1000", spmByteEnables); else n_pass++;
    n_checks++; if (dataToSpm !== 32'hA5A5_A5A5) $display("FAIL st_data: got %h expected a5a5a5a5", dataToSpm); else n_pass++;
    n_checks++; if (cpuDone !== 1'b0) $display("FAIL st_done_early: got %b expected 0", cpuDone); else n_pass++;
    ref_store(32'hC000_0003, 2'd0, 32'h1234_56A5);
    @(negedge clock); cpuRequest = 1'b0; #1;
    n_checks++; if ({cpuDone, cpuError} !== 2'b10) $display("FAIL st_done: got %b expected 10", {cpuDone, cpuError}); else n_pass++;
    n_checks++; if (spmCs !== 1'b0) $display("FAIL st_idle_cs: got %b expected 0", spmCs); else n_pass++;
    @(negedge clock); #1;
    n_checks++; if (cpuDone !== 1'b0) $display("FAIL st_done_pulse: got %b expected 0", cpuDone); else n_pass++;
  endtask

  task automatic test_load_extend();
    // Word 4 = 0x8081F00F
    @(negedge clock); drive(1'b1, 32'hC000_0010, 1'b1, 2'd2, 1'b0, 32'h8081_F00F);
    ref_store(32'hC000_0010, 2'd2, 32'h8081_F00F);
    @(negedge clock); cpuRequest = 1'b0;
    // Signed half load at offset 2
    @(negedge clock); drive(1'b1, 32'hC000_0012, 1'b0, 2'd1, 1'b1, 32'd0); #1;
    n_checks++; if ({spmCs, spmWe, spmAddress} !== {2'b10, 18'd4}) $display("FAIL ld_port: got cs%b we%b a%h expected cs1 we0 a4", spmCs, spmWe, spmAddress); else n_pass++;
    @(negedge clock); cpuRequest = 1'b0; #1;
    n_checks++; if ({cpuBusy, cpuDone} !== 2'b10) $display("FAIL ld_t1: got busy,done %b expected 10", {cpuBusy, cpuDone}); else n_pass++;
    @(negedge clock); #1;
    n_checks++; if ({cpuBusy, cpuDone} !== 2'b10) $display("FAIL ld_t2: got busy,done %b expected 10", {cpuBusy, cpuDone}); else n_pass++;
    @(negedge clock); #1;
    n_checks++; if ({cpuBusy, cpuDone, cpuError} !== 3'b010) $display("FAIL ld_t3: got busy,done,err %b expected 010", {cpuBusy, cpuDone, cpuError}); else n_pass++;
    n_checks++; if (cpuLoadData !== 32'hFFFF_8081) $display("FAIL ld_half_s: got %h expected ffff8081", cpuLoadData); else n_pass++;
    // Unsigned byte load at offset 0
    @(negedge clock); drive(1'b1, 32'hC000_0010, 1'b0, 2'd0, 1'b0, 32'd0);
    @(negedge clock); cpuRequest = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if ({cpuDone, cpuLoadData} !== {1'b1, 32'h0000_000F}) $display("FAIL ld_byte_u: got done%b %h expected done1 0000000f", cpuDone, cpuLoadData); else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    @(negedge clock); drive(1'b1, 32'hC000_0010, 1'b0, 2'd2, 1'b0, 32'd0);
    @(negedge clock); drive(1'b1, 32'hC000_0011, 1'b0, 2'd0, 1'b1, 32'd0); #1;
    n_checks++; if ({cpuBusy, spmCs} !== 2'b10) $display("FAIL b2b_t1: got busy,cs %b expected 10", {cpuBusy, spmCs}); else n_pass++;
    @(negedge clock); #1;
    n_checks++; if ({cpuBusy, spmCs} !== 2'b10) $display("FAIL b2b_t2: got busy,cs %b expected 10", {cpuBusy, spmCs}); else n_pass++;
    @(negedge clock); #1;
    n_checks++; if ({cpuBusy, cpuDone, spmCs} !== 3'b011) $display("FAIL b2b_t3: got busy,done,cs %b expected 011", {cpuBusy, cpuDone, spmCs}); else n_pass++;
    n_checks++; if (cpuLoadData !== 32'h8081_F00F) $display("FAIL b2b_first: got %h expected 8081f00f", cpuLoadData); else n_pass++;
    @(negedge clock); cpuRequest = 1'b0; #1;
    n_checks++; if ({cpuBusy, cpuDone} !== 2'b10) $display("FAIL b2b_t4: got busy,done %b expected 10", {cpuBusy, cpuDone}); else n_pass++;
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if ({cpuDone, cpuLoadData} !== {1'b1, 32'hFFFF_FFF0}) $display("FAIL b2b_second: got done%b %h expected done1 fffffff0", cpuDone, cpuLoadData); else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_misaligned_and_miss();
    @(negedge clock); drive(1'b1, 32'hC000_0006, 1'b0, 2'd2, 1'b0, 32'd0); #1;
    n_checks++; if ({cpuHit, spmCs} !== 2'b10) $display("FAIL mis_port: got hit,cs %b expected 10", {cpuHit, spmCs}); else n_pass++;
    @(negedge clock); cpuRequest = 1'b0; #1;
    n_checks++; if ({cpuDone, cpuError, cpuBusy} !== 3'b110) $display("FAIL mis_done: got done,err,busy %b expected 110", {cpuDone, cpuError, cpuBusy}); else n_pass++;
    @(negedge clock); #1;
    n_checks++; if ({cpuDone, cpuError} !== 2'b00) $display("FAIL mis_pulse: got %b expected 00", {cpuDone, cpuError}); else n_pass++;
    // Just past the window, then last word inside it
    drive(1'b1, 32'hC000_0800, 1'b0, 2'd2, 1'b0, 32'd0); #1;
    n_checks++; if ({cpuHit, spmCs} !== 2'b00) $display("FAIL miss_hi: got hit,cs %b expected 00", {cpuHit, spmCs}); else n_pass++;
    cpuAddress = 32'hBFFF_FFFC; #1;
    n_checks++; if ({cpuHit, spmCs} !== 2'b00) $display("FAIL miss_lo: got hit,cs %b expected 00", {cpuHit, spmCs}); else n_pass++;
    cpuAddress = 32'hC000_07FC; cpuWe = 1'b1; #1;
    n_checks++; if ({cpuHit, spmCs, spmAddress} !== {2'b11, 18'h1FF}) $display("FAIL hit_top: got hit%b cs%b a%h expected hit1 cs1 a1ff", cpuHit, spmCs, spmAddress); else n_pass++;
    cpuAddress = 32'hC000_0800; cpuWe = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    n_checks++; if ({cpuDone, cpuBusy} !== 2'b00) $display("FAIL miss_quiet: got done,busy %b expected 00", {cpuDone, cpuBusy}); else n_pass++;
    cpuRequest = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    @(negedge clock); drive(1'b1, 32'hC000_0010, 1'b0, 2'd2, 1'b0, 32'd0);
    @(negedge clock); cpuRequest = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0; #1;
    n_checks++; if ({cpuDone, cpuBusy, cpuLoadData} !== {2'b00, 32'd0}) $display("FAIL rst_mid: got done%b busy%b %h expected 0 0 0", cpuDone, cpuBusy, cpuLoadData); else n_pass++;
    @(negedge clock); #1;
    n_checks++; if (cpuDone !== 1'b0) $display("FAIL rst_no_done: got %b expected 0", cpuDone); else n_pass++;
    drive(1'b1, 32'hC000_0020, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF); #1;
    n_checks++; if ({spmCs, spmWe, spmByteEnables} !== 6'b110011) $display("FAIL rst_store: got cs%b we%b be%b expected 1 1 0011", spmCs, spmWe, spmByteEnables); else n_pass++;
    ref_store(32'hC000_0020, 2'd1, 32'h0000_BEEF);
    @(negedge clock); cpuRequest = 1'b0; #1;
    n_checks++; if (cpuDone !== 1'b1) $display("FAIL rst_store_done: got %b expected 1", cpuDone); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp_data;
    logic [1:0]  sz;
    logic        we, sg, mis;
    int          lat, exp_lat;
    // Fill the 16-word test region so every later load reads defined data
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      @(negedge clock); drive(1'b1, BASE + 32'(4 * w), 1'b1, 2'd2, 1'b0, d);
      ref_store(BASE + 32'(4 * w), 2'd2, d);
      @(negedge clock); cpuRequest = 1'b0;
    end
    for (int n = 0; n < 60; n++) begin
      a   = BASE + 32'($urandom_range(0, 63));
      sz  = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      d   = $urandom;
      mis = ref_misaligned(sz, a);
      if (!mis && int'(a - BASE) + nbytes(sz) > 64) continue;
      @(negedge clock); drive(1'b1, a, we, sz, sg, d); #1;
      n_checks++; if (spmCs !== !mis) $display("FAIL rnd_cs[%0d]: got %b expected %b", n, spmCs, !mis); else n_pass++;
      exp_data = ref_load(a, mis ? 2'd0 : sz, sg);
      if (we && !mis) ref_store(a, sz, d);
      exp_lat = (we || mis) ? 1 : 3;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clock); cpuRequest = 1'b0; #1;
        if (cpuDone) begin lat = k; break; end
      end
      n_checks++; if (lat !== exp_lat) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, exp_lat); else n_pass++;
      n_checks++; if (cpuError !== mis) $display("FAIL rnd_error[%0d]: got %b expected %b", n, cpuError, mis); else n_pass++;
      if (!we && !mis) begin
        n_checks++; if (cpuLoadData !== exp_data) $display("FAIL rnd_load[%0d]: addr %h size %0d got %h expected %h", n, a, sz, cpuLoadData, exp_data); else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_store_byte();
    test_load_extend();
    test_back_to_back();
    test_misaligned_and_miss();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
